int_div_lane: RTL and testbench

Iterative 32-bit integer divide lane: the inverse-operation companion to the integer ALU lane, implementing signed/unsigned quotient and remainder that the single-cycle lane does not provide. Radix-2 restoring divider with valid/ready handshakes on both sides, one operation in flight. Sits beside the integer ALU lanes in the integer pipeline and returns a tag so the issuing stage can route the writeback.

---
 rtl/int_div_lane.sv | 140 ++++++++++++++
 tb/tb_int_div_lane.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/int_div_lane.sv
// Iterative radix-2 restoring divider lane: signed/unsigned 32-bit quotient or
// remainder, one operation in flight, valid/ready on both sides, tag carried through.
module int_div_lane #(
  parameter int TAG_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          op0,
  input  logic [31:0]          op1,
  input  logic                 is_signed,
  input  logic                 want_rem,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          result,
  output logic [TAG_WIDTH-1:0] out_tag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                 state_q;
  logic [31:0]            dvd_q;
  logic [31:0]            rem_q;
  logic [31:0]            divisor_q;
  logic [4:0]             cnt_q;
  logic                   q_neg_q;
  logic                   r_neg_q;
  logic                   want_rem_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [31:0]            result_q;

  logic [31:0]            mag0_s;
  logic [31:0]            mag1_s;
  logic [32:0]            partial_s;
  logic [32:0]            trial_s;
  logic [31:0]            rem_d;
  logic [31:0]            dvd_d;
  logic [31:0]            quo_fix_s;
  logic [31:0]            rem_fix_s;
  logic [31:0]            fix_s;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign out_tag   = tag_q;

  // Operand magnitudes and one restoring step; a clear borrow bit means the divisor fits.
  always_comb begin
    mag0_s    = op0;
    mag1_s    = op1;
    if (is_signed && op0[31]) begin
      mag0_s = 32'd0 - op0;
    end else begin
      mag0_s = op0;
    end
    if (is_signed && op1[31]) begin
      mag1_s = 32'd0 - op1;
    end else begin
      mag1_s = op1;
    end
    partial_s = {rem_q, dvd_q[31]};
    trial_s   = partial_s - {1'b0, divisor_q};
    if (!trial_s[32]) begin
      rem_d = trial_s[31:0];
      dvd_d = {dvd_q[30:0], 1'b1};
    end else begin
      rem_d = partial_s[31:0];
      dvd_d = {dvd_q[30:0], 1'b0};
    end
    quo_fix_s = q_neg_q ? (32'd0 - dvd_q) : dvd_q;
    rem_fix_s = r_neg_q ? (32'd0 - rem_q) : rem_q;
    fix_s     = want_rem_q ? rem_fix_s : quo_fix_s;
  end

  // Control FSM and datapath registers; flush outranks both handshakes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      dvd_q      <= 32'd0;
      rem_q      <= 32'd0;
      divisor_q  <= 32'd0;
      cnt_q      <= 5'd0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      want_rem_q <= 1'b0;
      tag_q      <= {TAG_WIDTH{1'b0}};
      result_q   <= 32'd0;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            tag_q      <= in_tag;
            want_rem_q <= want_rem;
            q_neg_q    <= is_signed & (op0[31] ^ op1[31]);
            r_neg_q    <= is_signed & op0[31];
            dvd_q      <= mag0_s;
            divisor_q  <= mag1_s;
            rem_q      <= 32'd0;
            cnt_q      <= 5'd31;
            if (op1 == 32'd0) begin
              result_q <= want_rem ? op0 : 32'hFFFF_FFFF;
              state_q  <= DONE;
            end else begin
              state_q  <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          result_q <= fix_s;
          state_q  <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_div_lane.sv
// Randomized and directed bench for int_div_lane against an arithmetic reference model.
module tb_int_div_lane;
  localparam int TW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   op0 = 32'd0;
  logic [31:0]   op1 = 32'd0;
  logic          is_signed = 1'b0;
  logic          want_rem = 1'b0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   result;
  logic [TW-1:0] out_tag;

  int n_checks = 0;
  int n_errors = 0;

  int_div_lane #(.TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op0(op0), .op1(op1), .is_signed(is_signed), .want_rem(want_rem), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference: SV integer division truncates toward zero and % takes the dividend's sign.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn, input logic rem);
    longint sa, sb, q, r;
    if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return rem ? r[31:0] : q[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       input logic rem, input logic [TW-1:0] tag);
    int i;
    i = 0;
    while (!in_ready && i < 100) begin
      step();
      i++;
    end
    if (!in_ready) check_eq("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    op0 = a; op1 = b; is_signed = sgn; want_rem = rem; in_tag = tag;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("in_ready_busy", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic await_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic rem, input logic [TW-1:0] tag, input int hold);
    int lat;
    logic [31:0] exp;
    exp = ref_div(a, b, sgn, rem);
    issue(a, b, sgn, rem, tag);
    await_result(lat);
    check_eq("latency", lat, (b == 32'd0) ? 32'd1 : 32'd34);
    check_eq("result", result, exp);
    check_eq("out_tag", {{(32-TW){1'b0}}, out_tag}, {{(32-TW){1'b0}}, tag});
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      op0 = $urandom; op1 = $urandom; in_tag = TW'($urandom);
      step();
      check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
      check_eq("hold_result", result, exp);
      check_eq("hold_tag", {{(32-TW){1'b0}}, out_tag}, {{(32-TW){1'b0}}, tag});
      check_eq("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("post_xfer_valid", {31'd0, out_valid}, 32'd0);
    check_eq("post_xfer_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    logic [31:0] a, b;
    #12;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_tag", {{(32-TW){1'b0}}, out_tag}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();

    run_op(32'd100, 32'd7, 1'b0, 1'b0, 6'h15, 0);
    run_op(32'd100, 32'd7, 1'b0, 1'b1, 6'h15, 0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 6'h01, 0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 6'h02, 0);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 6'h03, 0);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 6'h04, 0);
    run_op(32'd5, 32'd0, 1'b1, 1'b0, 6'h05, 0);
    run_op(32'd5, 32'd0, 1'b1, 1'b1, 6'h06, 1);
    run_op(32'd5, 32'd0, 1'b0, 1'b0, 6'h07, 0);
    run_op(32'd5, 32'd0, 1'b0, 1'b1, 6'h08, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 6'h09, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 6'h0A, 0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 6'h0B, 10);

    // Flush ten cycles into CALC: the operation must never surface.
    issue(32'd100, 32'd7, 1'b0, 1'b0, 6'h10);
    for (int i = 0; i < 9; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("flush_calc_valid", {31'd0, out_valid}, 32'd0);
    check_eq("flush_calc_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 40; i++) step();
    check_eq("flush_calc_quiet", {31'd0, out_valid}, 32'd0);

    // Flush in DONE while out_ready is also high.
    issue(32'd50, 32'd5, 1'b0, 1'b0, 6'h11);
    await_result(lat);
    check_eq("flush_done_lat", lat, 32'd34);
    flush = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    out_ready = 1'b0;
    check_eq("flush_done_valid", {31'd0, out_valid}, 32'd0);
    check_eq("flush_done_ready", {31'd0, in_ready}, 32'd1);
    run_op(32'd9, 32'd3, 1'b0, 1'b0, 6'h12, 0);

    // Asynchronous reset mid-cycle during CALC.
    issue(32'd100, 32'd7, 1'b0, 1'b0, 6'h13);
    for (int i = 0; i < 5; i++) step();
    #2;
    reset = 1'b0;
    #1;
    check_eq("areset_valid", {31'd0, out_valid}, 32'd0);
    check_eq("areset_ready", {31'd0, in_ready}, 32'd1);
    check_eq("areset_result", result, 32'd0);
    check_eq("areset_tag", {{(32-TW){1'b0}}, out_tag}, 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    step();
    run_op(32'd1000, 32'd10, 1'b0, 1'b0, 6'h14, 0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: a = 32'h8000_0000;
        1: a = $urandom_range(0, 1000);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 20);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_op(a, b, 1'($urandom), 1'($urandom), TW'($urandom), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
